// File: rtl/gemm_tile_mac.sv
// Tile-level signed multiply-accumulate for a GEMM engine: accumulates T x W^T over
// successive K-tiles, one k column per cycle, and presents the finished C tile with a handshake.
module gemm_tile_mac #(
    parameter int S2P_SIZE   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        i_valid,
    input  logic                                        i_last,
    input  logic [S2P_SIZE*S2P_SIZE*DATA_WIDTH-1:0]     i_matrix_tensor,
    input  logic [S2P_SIZE*S2P_SIZE*DATA_WIDTH-1:0]     i_matrix_weight,
    output logic                                        o_in_ready,
    output logic [S2P_SIZE*S2P_SIZE*ACC_WIDTH-1:0]      o_result,
    output logic                                        o_valid,
    input  logic                                        i_ready,
    output logic                                        o_overrun
);

    localparam int NELEM  = S2P_SIZE * S2P_SIZE;
    localparam int TILE_W = NELEM * DATA_WIDTH;
    localparam int KW     = (S2P_SIZE > 1) ? $clog2(S2P_SIZE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(S2P_SIZE - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

    state_t                        state_q, state_d;
    logic [KW-1:0]                 k_q;
    logic                          last_p0;
    logic [TILE_W-1:0]             tensor_p0;
    logic [TILE_W-1:0]             weight_p0;
    logic                          overrun_q;
    logic signed [ACC_WIDTH-1:0]   acc_p1 [NELEM];

    function automatic logic signed [DATA_WIDTH-1:0] elem(input logic [TILE_W-1:0] tile,
                                                          input int idx);
        return tile[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Full-precision product, sign-extended; the accumulator add then wraps naturally.
    function automatic logic signed [ACC_WIDTH-1:0] wrap_product(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b);
        logic signed [2*DATA_WIDTH-1:0] prod;
        prod = a * b;
        return ACC_WIDTH'(prod);
    endfunction

    always_comb begin
        state_d    = state_q;
        o_valid    = 1'b0;
        o_in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                o_in_ready = !rstn;
                if (i_valid) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (k_q == K_LAST) state_d = last_p0 ? OUTPUT : IDLE;
            end
            OUTPUT: begin
                o_valid = 1'b1;
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= IDLE;
            k_q       <= '0;
            last_p0   <= 1'b0;
            tensor_p0 <= '0;
            weight_p0 <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NELEM; i++) acc_p1[i] <= '0;
        end else begin
            state_q <= state_d;
            // Tiles offered outside IDLE are dropped; only the sticky flag records them.
            if (i_valid && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        tensor_p0 <= i_matrix_tensor;
                        weight_p0 <= i_matrix_weight;
                        last_p0   <= i_last;
                        k_q       <= '0;
                    end
                end
                // ---- stage p0 -> p1: one k column of the outer product per cycle ----
                COMPUTE: begin
                    for (int r = 0; r < S2P_SIZE; r++) begin
                        for (int c = 0; c < S2P_SIZE; c++) begin
                            acc_p1[r*S2P_SIZE+c] <= acc_p1[r*S2P_SIZE+c]
                                + wrap_product(elem(tensor_p0, r*S2P_SIZE + int'(k_q)),
                                               elem(weight_p0, c*S2P_SIZE + int'(k_q)));
                        end
                    end
                    k_q <= k_q + KW'(1);
                end
                OUTPUT: begin
                    if (i_ready) begin
                        for (int i = 0; i < NELEM; i++) acc_p1[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NELEM; g++) begin : g_result
        assign o_result[g*ACC_WIDTH +: ACC_WIDTH] = acc_p1[g];
    end

    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_gemm_tile_mac.sv
// Directed bench for gemm_tile_mac (4x4 tiles, 8-bit operands, 32-bit accumulators).
module tb_gemm_tile_mac;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int TW = S*S*DW;
    localparam int RW = S*S*AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_last = 1'b0;
    logic          i_ready = 1'b0;
    logic [TW-1:0] t_in = '0;
    logic [TW-1:0] w_in = '0;
    logic [RW-1:0] o_result;
    logic          o_in_ready;
    logic          o_valid;
    logic          o_overrun;

    int total = 0;
    int bad   = 0;

    gemm_tile_mac #(.S2P_SIZE(S), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk),
        .rstn(rstn),
        .i_valid(i_valid),
        .i_last(i_last),
        .i_matrix_tensor(t_in),
        .i_matrix_weight(w_in),
        .o_in_ready(o_in_ready),
        .o_result(o_result),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [TW-1:0] tile_const(input int v);
        logic [TW-1:0] t;
        for (int i = 0; i < S*S; i++) t[i*DW +: DW] = DW'(v);
        return t;
    endfunction

    function automatic logic [TW-1:0] tile_rk();
        logic [TW-1:0] t;
        for (int r = 0; r < S; r++)
            for (int k = 0; k < S; k++) t[(r*S+k)*DW +: DW] = DW'(r + k);
        return t;
    endfunction

    function automatic logic [TW-1:0] tile_eye();
        logic [TW-1:0] t;
        for (int c = 0; c < S; c++)
            for (int k = 0; k < S; k++) t[(c*S+k)*DW +: DW] = DW'((c == k) ? 1 : 0);
        return t;
    endfunction

    function automatic logic [RW-1:0] res_const(input int v);
        logic [RW-1:0] t;
        for (int i = 0; i < S*S; i++) t[i*AW +: AW] = AW'(v);
        return t;
    endfunction

    function automatic logic [RW-1:0] res_rc();
        logic [RW-1:0] t;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) t[(r*S+c)*AW +: AW] = AW'(r + c);
        return t;
    endfunction

    task automatic send(input logic [TW-1:0] t, input logic [TW-1:0] w, input logic last);
        int n;
        n = 0;
        while (o_in_ready !== 1'b1) begin
            if (n == 20) begin
                $display("FAIL send_timeout in_ready=%b required=1", o_in_ready);
                $fatal(1, "input never accepted");
            end
            @(posedge clk); #1;
            n++;
        end
        t_in = t; w_in = w; i_last = last; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (o_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b req=0", o_in_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b req=0", o_valid); end
        total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b req=0", o_overrun); end
        total++; if (o_result !== '0) begin bad++; $display("FAIL rst_result got=%h req=0", o_result); end
        rstn = 1'b0;
        #1;
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b req=1", o_in_ready); end
    endtask

    task automatic test_identity();
        int lat;
        send(tile_rk(), tile_eye(), 1'b1);
        wait_out(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL ident_latency got=%0d req=4", lat); end
        total++; if (o_result !== res_rc()) begin bad++; $display("FAIL ident_result got=%h req=%h", o_result, res_rc()); end
        total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL ident_ready_in_output got=%b req=0", o_in_ready); end
        ack();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ident_valid_after_ack got=%b req=0", o_valid); end
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL ident_ready_after_ack got=%b req=1", o_in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int seen;
        send(tile_const(1), tile_const(1), 1'b0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (o_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL b2b_early_valid got=%0d req=0", seen); end
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rate_ready got=%b req=1", o_in_ready); end
        send(tile_const(1), tile_const(1), 1'b1);
        wait_out(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL b2b_latency got=%0d req=4", lat); end
        total++; if (o_result !== res_const(8)) begin bad++; $display("FAIL b2b_result got=%h req=%h", o_result, res_const(8)); end
        ack();
    endtask

    task automatic test_extremes();
        int lat;
        send(tile_const(-128), tile_const(-128), 1'b1);
        wait_out(lat);
        total++; if (o_result !== res_const(65536)) begin bad++; $display("FAIL ext_negneg got=%h req=%h", o_result, res_const(65536)); end
        ack();
        send(tile_const(127), tile_const(-128), 1'b1);
        wait_out(lat);
        total++; if (o_result !== res_const(-65024)) begin bad++; $display("FAIL ext_posneg got=%h req=%h", o_result, res_const(-65024)); end
        ack();
    endtask

    task automatic test_overrun();
        int lat;
        total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL ovr_initial got=%b req=0", o_overrun); end
        send(tile_const(1), tile_const(1), 1'b1);
        @(posedge clk); #1;
        t_in = tile_const(5); w_in = tile_const(5); i_last = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b req=1", o_overrun); end
        wait_out(lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL ovr_latency got=%0d req=2", lat); end
        total++; if (o_result !== res_const(4)) begin bad++; $display("FAIL ovr_result got=%h req=%h", o_result, res_const(4)); end
        ack();
        total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b req=1", o_overrun); end
    endtask

    task automatic test_backpressure();
        int lat;
        send(tile_const(1), tile_const(1), 1'b1);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (o_valid !== 1'b1 || o_result !== res_const(4)) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d valid=%b result=%h req_valid=1 req_result=%h", i, o_valid, o_result, res_const(4));
            end
            @(posedge clk); #1;
        end
        ack();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after_ack got=%b req=0", o_valid); end
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_ack got=%b req=1", o_in_ready); end
        send(tile_rk(), tile_eye(), 1'b1);
        wait_out(lat);
        total++; if (o_result !== res_rc()) begin bad++; $display("FAIL bp_fresh_acc got=%h req=%h", o_result, res_rc()); end
        ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        send(tile_const(1), tile_const(1), 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_valid_seen got=%0d req=0", seen); end
        total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL rmid_overrun got=%b req=0", o_overrun); end
        total++; if (o_result !== '0) begin bad++; $display("FAIL rmid_acc_cleared got=%h req=0", o_result); end
        send(tile_const(1), tile_const(1), 1'b1);
        wait_out(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL rmid_latency got=%0d req=4", lat); end
        total++; if (o_result !== res_const(4)) begin bad++; $display("FAIL rmid_result got=%h req=%h", o_result, res_const(4)); end
        ack();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_extremes();
        test_overrun();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
